// File: rtl/int_sched.sv
// int_sched: interrupt scheduler for the device bus (window 0x7f20-0x7f2f).
// Latches up to N_SRC interrupt lines into pending bits, masks them, and
// presents the lowest-index request to CP0 with an ack / EOI handshake.
// Optional build macro INT_SCHED_LAT_CNT_EN adds a request-latency counter
// readable at word offset 3.
module int_sched #(
    parameter int unsigned           N_SRC     = 4,
    parameter logic [N_SRC-1:0]      EDGE_MASK = 'b0011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             int_ack,
    output logic             irq_out,
    output logic [3:0]       irq_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2,
        BAD  = 2'd3
    } state_t;

    localparam logic [15:0] EDGE16 = 16'(EDGE_MASK);

    state_t           r_state;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_prev;
    logic             r_irq_out;
    logic [3:0]       r_irq_id;

    logic [N_SRC-1:0] w_req;
    logic [15:0]      w_req16;
    logic             w_cur_req;
    logic [3:0]       w_winner;
    logic             w_found;
    logic             w_eoi;
    logic [N_SRC-1:0] w_w1c;
    logic             w_ack_take;
    logic [15:0]      w_ack_clr16;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_pend_nxt;
    logic             w_unused;

    assign irq_out  = r_irq_out;
    assign irq_id   = r_irq_id;
    assign w_unused = ^wdata;

    // Request vector, priority pick and pending-bit next state.
    always_comb begin
        w_req   = r_pend & r_mask;
        w_req16 = '0;
        w_req16[N_SRC-1:0] = w_req;
        w_cur_req = w_req16[r_irq_id];

        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_req[i] && !w_found) begin
                w_winner = 4'(i);
                w_found  = 1'b1;
            end
        end

        w_eoi = we && (addr == 2'd2);
        w_w1c = (we && (addr == 2'd0)) ? wdata[N_SRC-1:0] : '0;

        // A dropped request beats an ack in the same cycle.
        w_ack_take  = (r_state == REQ) && w_cur_req && int_ack;
        w_ack_clr16 = '0;
        if (w_ack_take)
            w_ack_clr16[r_irq_id] = EDGE16[r_irq_id];
        w_ack_clr = w_ack_clr16[N_SRC-1:0];

        w_set      = (irq_in & ~r_prev & EDGE_MASK) | (irq_in & ~EDGE_MASK);
        // Clears first, then sets, so a new event always survives.
        w_pend_nxt = (r_pend & ~(w_w1c | w_ack_clr)) | w_set;
    end

    // Pending, mask and edge-history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_prev <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_prev <= irq_in;
            if (we && (addr == 2'd1))
                r_mask <= wdata[N_SRC-1:0];
        end
    end

    // Request / service handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_irq_out <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_state   <= REQ;
                        r_irq_out <= 1'b1;
                        r_irq_id  <= w_winner;
                    end
                end
                REQ: begin
                    if (!w_cur_req) begin
                        r_state   <= IDLE;
                        r_irq_out <= 1'b0;
                        r_irq_id  <= '0;
                    end else if (int_ack) begin
                        r_state   <= SERV;
                        r_irq_out <= 1'b0;
                    end
                end
                SERV: begin
                    r_irq_out <= 1'b0;
                    if (w_eoi) begin
                        r_state  <= IDLE;
                        r_irq_id <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_irq_out <= 1'b0;
                    r_irq_id  <= '0;
                end
            endcase
        end
    end

`ifdef INT_SCHED_LAT_CNT_EN
    logic [31:0] r_lat_cnt;

    // Cycles spent in REQ for the latest request; saturating, holds outside REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_lat_cnt <= '0;
        else if (we && (addr == 2'd3))
            r_lat_cnt <= '0;
        else if ((r_state == IDLE) && (|w_req))
            r_lat_cnt <= '0;
        else if ((r_state == REQ) && (r_lat_cnt != '1))
            r_lat_cnt <= r_lat_cnt + 32'd1;
    end
`endif

    // Combinational register read mux.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[N_SRC-1:0] = r_pend;
            2'd1: rdata[N_SRC-1:0] = r_mask;
            2'd2: begin
                rdata[3:0] = r_irq_id;
                rdata[4]   = r_irq_out;
                rdata[9:8] = r_state;
            end
            default: begin
`ifdef INT_SCHED_LAT_CNT_EN
                rdata = r_lat_cnt;
`else
                rdata = '0;
`endif
            end
        endcase
    end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Interrupt scheduler on the device bus, alongside the two timers, decoded at 0x00007f20–0x00007f2f.
- Collects up to N_SRC device interrupt lines (timer T0, timer T1, external) into pending bits and applies a mask.
- Picks the highest-priority request and presents one interrupt to CP0, with an acknowledge / end-of-interrupt (EOI) handshake.
- Only one interrupt is in service at a time.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16). Index 0 has the highest priority.
- EDGE_MASK, 4'b0011, per-source trigger type: 1 = rising-edge, 0 = level.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- addr  in  2  word offset within the window (ADDR[3:2]).
- we  in  1  write enable, already qualified by the window decode.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr.
- irq_in  in  N_SRC  device interrupt lines, synchronous to clk.
- int_ack  in  1  one-cycle pulse from CP0 on exception entry.
- irq_out  out  1  registered interrupt request to CP0.
- irq_id  out  4  registered index of the source being requested or serviced.

Behaviour:
- Register map, by addr:
  - 0 = PEND. Read gives the pending bits. Write is write-1-to-clear.
  - 1 = MASK. Read/write, 1 = enabled.
  - 2 = STATUS on read: [3:0]=irq_id, [4]=irq_out, [9:8]=state. A write to addr 2 is EOI (data ignored).
  - 3 = reserved. Reads 0, writes ignored.
  - Bits at or above N_SRC read 0 and ignore writes.
- Reset state: pend=0, mask=0, prev_irq=0, state=IDLE, irq_out=0, irq_id=0.
- Edge sources: the pend bit is set at a clk edge where irq_in=1 and prev_irq=0. prev_irq registers irq_in every cycle.
- Level sources: the pend bit is set at every edge where irq_in=1. A W1C does not hold while the line stays high.
- Set and W1C on the same bit in the same cycle: set wins.
- req = pend & mask. The winner is the lowest set index of req.
- State encoding: IDLE=0, REQ=1, SERV=2. Value 3 is unreachable and recovers to IDLE.
- IDLE:
  - If req != 0, go to REQ, latch irq_id = winner, set irq_out=1.
  - Latency: irq_in rises at edge t, pend is set at t, irq_out is high after t+1.
- REQ:
  - irq_id is frozen; higher-priority arrivals do not preempt.
  - On int_ack: go to SERV, set irq_out=0, and clear pend[irq_id] if that source is edge-triggered. That clear beats the W1C path but loses to a new edge in the same cycle.
  - If req[irq_id] drops before ack (masked or W1C'd): go to IDLE, irq_out=0 next cycle. This has priority over int_ack in the same cycle.
- SERV:
  - irq_out=0, irq_id holds.
  - EOI write goes to IDLE. Re-arbitration starts the following cycle, so there is at least one idle cycle between interrupts.
- int_ack outside REQ is ignored. EOI outside SERV is ignored.
- Reset asserted mid-operation clears everything immediately (asynchronous). Pending events are lost.
- MASK writes take effect for arbitration on the next cycle.

Optional Feature:
- Macro: INT_SCHED_LAT_CNT_EN.
- When defined:
  - A 32-bit latency counter is reset to 0 on entering REQ and increments each cycle in REQ, saturating at 0xFFFFFFFF.
  - It holds on leaving REQ.
  - It is readable at addr 3; writes to addr 3 clear it to 0.
  - Reset value is 0.
- When undefined: addr 3 reads 0, and no counter logic exists.

Test Plan:
- Reset, then read addr 0/1/2 -> all 0x00000000. irq_out=0.
- MASK=0x3. Pulse irq_in[1] high for 1 cycle at edge t -> PEND=0x2 after t, irq_out=1 and irq_id=1 after t+1. int_ack -> irq_out=0, PEND=0x0, STATUS[9:8]=2. EOI write -> STATUS=0x0 next cycle.
- MASK=0xF. Raise irq_in[2] (level) and irq_in[0] (edge) in the same cycle -> irq_id=0 first. After ack+EOI, irq_id=2 while irq_in[2] is held high. Drop irq_in[2] and W1C 0x4 -> PEND=0, irq_out stays 0.
- In REQ for id 1, clear MASK to 0x0 -> irq_out=0 the next cycle, state IDLE, PEND still 0x2. Re-enable MASK=0x2 -> REQ re-enters with irq_id=1.
- Edge on irq_in[0] in the same cycle as a W1C of 0x1 -> PEND bit 0 stays 1. Assert reset in SERV -> all registers 0 asynchronously.
- INT_SCHED_LAT_CNT_EN defined: enter REQ, ack after 5 cycles -> addr 3 reads 5. Write addr 3 -> reads 0.
